// File: rtl/fpu_share_arbiter.sv
// fpu_share_arbiter: round-robin sharing of one stb/ack floating-point unit
// (adder or multiplier) among NREQ requesters. One operand pair is accepted
// per grant; the A, B and Z handshakes run in order, and the result goes back
// only to the requester that owns the operation.
// Optional build macro FPU_ARB_OPCNT_EN adds the op_count and busy outputs.

// Per-requester slice: accept pulse decode and the owner's result-valid flag.
module fpu_share_arbiter_lane #(
  parameter int unsigned IDX = 0,
  parameter int unsigned IDW = 2
) (
  input  logic           iClk,
  input  logic           iRstn,
  input  logic           grant_i,   // an arbitration win happens this cycle
  input  logic [IDW-1:0] win_i,     // winning requester id
  input  logic           set_i,     // result captured this cycle
  input  logic           clr_i,     // owner acknowledged the result
  input  logic [IDW-1:0] own_i,     // owner of the in-flight operation
  output logic           ready_o,
  output logic           resp_valid_o
);

  logic mine;
  logic resp_valid_q;

  assign mine         = (own_i == IDW'(IDX));
  assign ready_o      = grant_i && (win_i == IDW'(IDX));
  assign resp_valid_o = resp_valid_q;

  // Result-valid flag: raised when the owner's result is captured, dropped on its ack.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn)              resp_valid_q <= 1'b0;
    else if (set_i && mine)  resp_valid_q <= 1'b1;
    else if (clr_i && mine)  resp_valid_q <= 1'b0;
  end

endmodule

module fpu_share_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 32
) (
  input  logic                 iClk,
  input  logic                 iRstn,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DW-1:0]   req_a,
  input  logic [NREQ*DW-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      resp_valid,
  output logic [DW-1:0]        resp_data,
  input  logic [NREQ-1:0]      resp_ack,
  output logic [DW-1:0]        fpu_input_a,
  output logic [DW-1:0]        fpu_input_b,
  output logic                 fpu_a_stb,
  output logic                 fpu_b_stb,
  input  logic                 fpu_a_ack,
  input  logic                 fpu_b_ack,
  input  logic [DW-1:0]        fpu_z,
  input  logic                 fpu_z_stb,
  output logic                 fpu_z_ack
`ifdef FPU_ARB_OPCNT_EN
  ,
  output logic [31:0]          op_count,
  output logic                 busy
`endif
);

  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_Z, RESP} state_e;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } opnd_t;

  state_e                    state_q, state_d;
  opnd_t                     op_q;
  logic [DW-1:0]             res_q;
  logic [IDW-1:0]            own_q, ptr_q;
  logic [IDW-1:0]            win;
  logic                      win_vld;
  logic                      grant;
  logic                      z_take;
  logic                      resp_done;
  logic [NREQ-1:0][DW-1:0]   req_a_v, req_b_v;

  assign req_a_v = req_a;
  assign req_b_v = req_b;

  // Round-robin scan starting just after the last served requester.
  always_comb begin
    logic [IDW-1:0] cand;
    win     = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDW'((32'(ptr_q) + k) % NREQ);
      if (!win_vld && req_valid[cand]) begin
        win_vld = 1'b1;
        win     = cand;
      end
    end
  end

  // Accept is combinational in IDLE; gated by reset so nothing is granted while held.
  assign grant     = iRstn && (state_q == IDLE) && win_vld;
  assign z_take    = (state_q == WAIT_Z) && fpu_z_stb;
  assign resp_done = (state_q == RESP) && resp_ack[own_q];

  // State register.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: one operation walks A -> B -> Z -> result handback.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (win_vld)    state_d = SEND_A;
      SEND_A:  if (fpu_a_ack)  state_d = SEND_B;
      SEND_B:  if (fpu_b_ack)  state_d = WAIT_Z;
      WAIT_Z:  if (fpu_z_stb)  state_d = RESP;
      RESP:    if (resp_done)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Handshake outputs: exactly one of the unit strobes per state, held until acked.
  always_comb begin
    fpu_a_stb = (state_q == SEND_A);
    fpu_b_stb = (state_q == SEND_B);
    fpu_z_ack = (state_q == WAIT_Z);
  end

  // Operand capture on grant, result capture on Z, pointer update on owner ack.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      op_q  <= '0;
      res_q <= '0;
      own_q <= '0;
      ptr_q <= IDW'(NREQ - 1);
    end else begin
      if (grant) begin
        op_q.a <= req_a_v[win];
        op_q.b <= req_b_v[win];
        own_q  <= win;
      end
      if (z_take)    res_q <= fpu_z;
      if (resp_done) ptr_q <= own_q;
    end
  end

  // Operand buses simply show the latched pair; they hold between operations.
  assign fpu_input_a = op_q.a;
  assign fpu_input_b = op_q.b;
  assign resp_data   = res_q;

  for (genvar g = 0; g < NREQ; g++) begin : g_lane
    fpu_share_arbiter_lane #(
      .IDX (g),
      .IDW (IDW)
    ) u_lane (
      .iClk         (iClk),
      .iRstn        (iRstn),
      .grant_i      (grant),
      .win_i        (win),
      .set_i        (z_take),
      .clr_i        (resp_done),
      .own_i        (own_q),
      .ready_o      (req_ready[g]),
      .resp_valid_o (resp_valid[g])
    );
  end

`ifdef FPU_ARB_OPCNT_EN
  logic [31:0] op_count_q;

  // Completed-operation counter, free-running wrap.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn)         op_count_q <= '0;
    else if (resp_done) op_count_q <= op_count_q + 32'd1;
  end

  assign op_count = op_count_q;
  assign busy     = (state_q != IDLE);
`endif

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Directed bench for fpu_share_arbiter with a table-driven multiplier stub
// that has programmable A-ack and Z latency.
module tb_fpu_share_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;

  logic                iClk = 1'b0;
  logic                iRstn;
  logic [NREQ-1:0]     req_valid, req_ready, resp_valid, resp_ack;
  logic [NREQ*DW-1:0]  req_a, req_b;
  logic [DW-1:0]       resp_data, fpu_input_a, fpu_input_b, fpu_z;
  logic                fpu_a_stb, fpu_b_stb, fpu_a_ack, fpu_b_ack, fpu_z_stb, fpu_z_ack;
`ifdef FPU_ARB_OPCNT_EN
  logic [31:0]         op_count;
  logic                busy;
`endif

  int n_vec = 0;
  int n_err = 0;
  int strb_viol = 0;

  fpu_share_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .iClk        (iClk),
    .iRstn       (iRstn),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .resp_ack    (resp_ack),
    .fpu_input_a (fpu_input_a),
    .fpu_input_b (fpu_input_b),
    .fpu_a_stb   (fpu_a_stb),
    .fpu_b_stb   (fpu_b_stb),
    .fpu_a_ack   (fpu_a_ack),
    .fpu_b_ack   (fpu_b_ack),
    .fpu_z       (fpu_z),
    .fpu_z_stb   (fpu_z_stb),
    .fpu_z_ack   (fpu_z_ack)
`ifdef FPU_ARB_OPCNT_EN
    ,
    .op_count    (op_count),
    .busy        (busy)
`endif
  );

  always #5 iClk = ~iClk;

  // ---------------- multiplier stub ----------------
  int            a_dly = 0, b_dly = 0, z_dly = 0;
  int            a_cnt, b_cnt, z_cnt;
  logic          z_pend;
  logic [DW-1:0] sa, z_val;

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h40400000_40000000: fmul = 32'h40C00000; // 3.0 * 2.0
      64'h3F800000_3F800000: fmul = 32'h3F800000; // 1.0 * 1.0
      64'h40000000_40000000: fmul = 32'h40800000; // 2.0 * 2.0
      64'h3FC00000_40000000: fmul = 32'h40400000; // 1.5 * 2.0
      64'h40800000_3F000000: fmul = 32'h40000000; // 4.0 * 0.5
      64'h40200000_40000000: fmul = 32'h40A00000; // 2.5 * 2.0
      default:               fmul = 32'h00000000;
    endcase
  endfunction

  assign fpu_a_ack = fpu_a_stb && (a_cnt >= a_dly);
  assign fpu_b_ack = fpu_b_stb && (b_cnt >= b_dly);
  assign fpu_z_stb = z_pend && (z_cnt == 0);
  assign fpu_z     = fpu_z_stb ? z_val : '0;

  always @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      a_cnt <= 0; b_cnt <= 0; z_cnt <= 0; z_pend <= 1'b0; sa <= '0; z_val <= '0;
    end else begin
      a_cnt <= (fpu_a_stb && !fpu_a_ack) ? a_cnt + 1 : 0;
      b_cnt <= (fpu_b_stb && !fpu_b_ack) ? b_cnt + 1 : 0;
      if (fpu_a_stb && fpu_a_ack) sa <= fpu_input_a;
      if (fpu_b_stb && fpu_b_ack) begin
        z_pend <= 1'b1;
        z_cnt  <= z_dly;
        z_val  <= fmul(sa, fpu_input_b);
      end else if (z_pend) begin
        if (z_cnt != 0)     z_cnt  <= z_cnt - 1;
        else if (fpu_z_ack) z_pend <= 1'b0;
      end
    end
  end

  // Strobe exclusivity watcher.
  always @(negedge iClk)
    if (iRstn && ((32'(fpu_a_stb) + 32'(fpu_b_stb) + 32'(fpu_z_ack)) > 32'd1))
      strb_viol++;

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
    req_valid[i]      = 1'b1;
  endtask

  // Wait for the accept pulse, check it is one-hot for i, drop the request
  // after the accepting edge, and check the pulse lasted one cycle.
  task automatic wait_grant(input int i);
    int t = 0;
    #1;
    while (req_ready == '0 && t < 40) begin @(negedge iClk); t++; end
    check($sformatf("grant%0d", i), 32'(req_ready), 32'(1) << i);
    @(posedge iClk);
    #1 req_valid[i] = 1'b0;
    @(negedge iClk);
    check($sformatf("ready_pulse%0d", i), 32'(req_ready), 32'd0);
  endtask

  // Wait for the result, hold it for 'hold' cycles, then ack it.
  task automatic wait_resp(input int i, input logic [31:0] exp, input int hold);
    int t = 0;
    while (resp_valid == '0 && t < 80) begin @(negedge iClk); t++; end
    check($sformatf("resp_valid%0d", i), 32'(resp_valid), 32'(1) << i);
    check($sformatf("resp_data%0d", i), resp_data, exp);
    for (int h = 0; h < hold; h++) begin
      @(negedge iClk);
      check("resp_hold_valid", 32'(resp_valid), 32'(1) << i);
      check("resp_hold_data", resp_data, exp);
      check("no_ready_in_resp", 32'(req_ready), 32'd0);
    end
    resp_ack[i] = 1'b1;
    @(negedge iClk);
    resp_ack[i] = 1'b0;
    #1;
    check($sformatf("resp_clear%0d", i), 32'(resp_valid), 32'd0);
  endtask

  task automatic reset_pulse();
    iRstn = 1'b0;
    repeat (2) @(negedge iClk);
    iRstn = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t;
    iRstn = 1'b0; req_valid = '0; resp_ack = '0; req_a = '0; req_b = '0;
    #1;
    check("rst_ready",  32'(req_ready), 32'd0);
    check("rst_rvalid", 32'(resp_valid), 32'd0);
    check("rst_rdata",  resp_data, 32'd0);
    check("rst_strobes", {29'd0, fpu_a_stb, fpu_b_stb, fpu_z_ack}, 32'd0);
    check("rst_opnd",   fpu_input_a | fpu_input_b, 32'd0);
    @(negedge iClk); @(negedge iClk);
    iRstn = 1'b1;

    // T1: single request, full handshake walk.
    @(negedge iClk);
`ifdef FPU_ARB_OPCNT_EN
    check("busy_idle", 32'(busy), 32'd0);
`endif
    set_req(0, 32'h40400000, 32'h40000000);
    wait_grant(0);
    check("t1_a_stb", {30'd0, fpu_a_stb, fpu_b_stb}, 32'd2);
    check("t1_in_a", fpu_input_a, 32'h40400000);
`ifdef FPU_ARB_OPCNT_EN
    check("busy_send_a", 32'(busy), 32'd1);
`endif
    @(negedge iClk);
    check("t1_b_stb", {30'd0, fpu_a_stb, fpu_b_stb}, 32'd1);
    check("t1_in_b", fpu_input_b, 32'h40000000);
    @(negedge iClk);
    check("t1_z_ack", 32'(fpu_z_ack), 32'd1);
    wait_resp(0, 32'h40C00000, 0);
    check("t1_strobes_idle", {29'd0, fpu_a_stb, fpu_b_stb, fpu_z_ack}, 32'd0);
    check("t1_in_a_hold", fpu_input_a, 32'h40400000);
`ifdef FPU_ARB_OPCNT_EN
    check("busy_done", 32'(busy), 32'd0);
`endif

    // T2: all four pending after reset -> 0,1,2,3, re-arbitration one cycle after ack.
    @(negedge iClk);
    reset_pulse();
`ifdef FPU_ARB_OPCNT_EN
    force dut.op_count_q = 32'hFFFFFFFE;
    #1 release dut.op_count_q;
`endif
    set_req(0, 32'h3F800000, 32'h3F800000);
    set_req(1, 32'h40000000, 32'h40000000);
    set_req(2, 32'h3FC00000, 32'h40000000);
    set_req(3, 32'h40800000, 32'h3F000000);
    wait_grant(0);
    wait_resp(0, 32'h3F800000, 0);
`ifdef FPU_ARB_OPCNT_EN
    check("opcnt_ffff", op_count, 32'hFFFFFFFF);
`endif
    check("t2_rearb1", 32'(req_ready), 32'h2);
    wait_grant(1);
    wait_resp(1, 32'h40800000, 0);
`ifdef FPU_ARB_OPCNT_EN
    check("opcnt_wrap", op_count, 32'h0);
`endif
    check("t2_rearb2", 32'(req_ready), 32'h4);
    wait_grant(2);
    wait_resp(2, 32'h40400000, 0);
    check("t2_rearb3", 32'(req_ready), 32'h8);
    wait_grant(3);
    wait_resp(3, 32'h40000000, 0);

    // T3: serve 1, then 0 and 2 together -> 2 first, then 0.
    set_req(1, 32'h40200000, 32'h40000000);
    wait_grant(1);
    wait_resp(1, 32'h40A00000, 0);
    set_req(0, 32'h3FC00000, 32'h40000000);
    set_req(2, 32'h40000000, 32'h40000000);
    wait_grant(2);
    wait_resp(2, 32'h40800000, 0);
    check("t3_rearb0", 32'(req_ready), 32'h1);
    wait_grant(0);
    wait_resp(0, 32'h40400000, 0);

    // T4: slow unit, slow consumer, foreign ack ignored.
    a_dly = 3; z_dly = 7;
    set_req(1, 32'h40400000, 32'h40000000);
    wait_grant(1);
    set_req(2, 32'h3F800000, 32'h3F800000);
    check("t4_a_stb0", 32'(fpu_a_stb), 32'd1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge iClk);
      check("t4_a_stb_hold", 32'(fpu_a_stb), 32'd1);
      check("t4_in_a_hold", fpu_input_a, 32'h40400000);
      check("t4_no_ready", 32'(req_ready), 32'd0);
    end
    resp_ack[2] = 1'b1;
    wait_resp(1, 32'h40C00000, 5);
    check("t4_rearb2", 32'(req_ready), 32'h4);
    resp_ack[2] = 1'b0;
    wait_grant(2);
    wait_resp(2, 32'h3F800000, 0);

    // T5: reset during WAIT_Z; afterwards 3 and 0 pending -> 0 first.
    a_dly = 0;
    set_req(3, 32'h40200000, 32'h40000000);
    wait_grant(3);
    t = 0;
    while (!fpu_z_ack && t < 20) begin @(negedge iClk); t++; end
    check("t5_in_waitz", 32'(fpu_z_ack), 32'd1);
    set_req(3, 32'h40200000, 32'h40000000);
    set_req(0, 32'h40800000, 32'h3F000000);
    #2 iRstn = 1'b0;
    #1;
    check("t5_rst_ready",  32'(req_ready), 32'd0);
    check("t5_rst_rvalid", 32'(resp_valid), 32'd0);
    check("t5_rst_strobes", {29'd0, fpu_a_stb, fpu_b_stb, fpu_z_ack}, 32'd0);
    check("t5_rst_data",   resp_data | fpu_input_a | fpu_input_b, 32'd0);
    @(negedge iClk); @(negedge iClk);
    iRstn = 1'b1;
    wait_grant(0);
    wait_resp(0, 32'h40000000, 0);
    check("t5_rearb3", 32'(req_ready), 32'h8);
    wait_grant(3);
    wait_resp(3, 32'h40A00000, 0);

    check("strobe_exclusive", 32'(strb_viol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
